// File: rtl/gpio_event_logger.sv
// rtl/gpio_event_logger.sv - timestamped GPIO change logger with round-robin capture into an FWFT FIFO
// Each port keeps a one-deep snapshot; repeated changes before capture coalesce and are counted as lost.
module gpio_event_logger #(
  parameter int NUM_PORTS = 3,
  parameter int PORT_W    = 8,
  parameter int IDX_W     = 3,
  parameter int TS_W      = 32,
  parameter int DEPTH     = 16,
  parameter int LVL_W     = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [NUM_PORTS-1:0]        watch_mask,
  input  logic [NUM_PORTS*PORT_W-1:0] port_out,
  input  logic [NUM_PORTS*PORT_W-1:0] port_dir,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [IDX_W-1:0]            ev_port,
  output logic [PORT_W-1:0]           ev_data,
  output logic [PORT_W-1:0]           ev_dir,
  output logic [TS_W-1:0]             ev_time,
  output logic                        ev_lost,
  output logic [15:0]                 drop_count,
  output logic [LVL_W-1:0]            fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = IDX_W + 2*PORT_W + TS_W + 1;
  localparam int CW = $clog2(NUM_PORTS + 1);

  logic [TS_W-1:0]   ts;
  logic [PORT_W-1:0] prev      [NUM_PORTS];
  logic [PORT_W-1:0] snap_data [NUM_PORTS];
  logic [PORT_W-1:0] snap_dir  [NUM_PORTS];
  logic [TS_W-1:0]   snap_ts   [NUM_PORTS];
  logic [NUM_PORTS-1:0] pending, lost, det;
  logic [IDX_W-1:0]  rr, grant_idx, hi_idx, lo_idx;
  logic              hi_found, lo_found, grant_found;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  count, count_next;
  logic              pop, push, full, head_from_push;
  logic [EW-1:0]     push_entry, head_entry;
  logic [CW-1:0]     n_coal;
  logic [16:0]       drop_sum;

  assign fifo_level = count;
  assign full       = (count == LVL_W'(DEPTH));
  assign pop        = ev_valid && ev_ready;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++)
      det[p] = enable && watch_mask[p] && (port_out[p*PORT_W +: PORT_W] != prev[p]);
  end

  // Reverse scan leaves the lowest matching index in each candidate.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (pending[p]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(p);
        if (IDX_W'(p) >= rr) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(p);
        end
      end
    end
    grant_found = lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign push = grant_found && (!full || pop);

  always_comb begin
    push_entry = '0;
    n_coal     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_idx == IDX_W'(p))
        push_entry = {IDX_W'(p), snap_data[p], snap_dir[p], snap_ts[p], lost[p]};
      if (det[p] && pending[p] && !(push && grant_idx == IDX_W'(p)))
        n_coal = n_coal + CW'(1);
    end
    drop_sum = {1'b0, drop_count} + 17'(n_coal);
  end

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + LVL_W'(1);
    else if (!push && pop)
      count_next = count - LVL_W'(1);
    head_from_push = (count == '0) || (count == LVL_W'(1) && pop);
    head_entry     = head_from_push ? push_entry : mem[rd_ptr + AW'(pop)];
  end

  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      pending    <= '0;
      lost       <= '0;
      rr         <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      ev_valid   <= 1'b0;
      ev_port    <= '0;
      ev_data    <= '0;
      ev_dir     <= '0;
      ev_time    <= '0;
      ev_lost    <= 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        prev[p]      <= '0;
        snap_data[p] <= '0;
        snap_dir[p]  <= '0;
        snap_ts[p]   <= '0;
      end
    end else begin
      ts <= ts + TS_W'(1);
      for (int p = 0; p < NUM_PORTS; p++)
        prev[p] <= port_out[p*PORT_W +: PORT_W];
      if (clear) begin
        ts         <= '0;
        pending    <= '0;
        lost       <= '0;
        rr         <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        count      <= '0;
        drop_count <= '0;
        ev_valid   <= 1'b0;
      end else begin
        // A detection on the push edge overrides the clear of that port's pending bit.
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (push && grant_idx == IDX_W'(p)) begin
            pending[p] <= 1'b0;
            lost[p]    <= 1'b0;
          end
          if (det[p]) begin
            pending[p]   <= 1'b1;
            snap_data[p] <= port_out[p*PORT_W +: PORT_W];
            snap_dir[p]  <= port_dir[p*PORT_W +: PORT_W];
            snap_ts[p]   <= ts;
            if (pending[p] && !(push && grant_idx == IDX_W'(p)))
              lost[p] <= 1'b1;
          end
        end
        drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (grant_idx == IDX_W'(NUM_PORTS - 1))
            rr <= '0;
          else
            rr <= grant_idx + IDX_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count    <= count_next;
        ev_valid <= (count_next != '0);
        if (count_next != '0) begin
          ev_port <= head_entry[EW-1 -: IDX_W];
          ev_data <= head_entry[EW-1-IDX_W -: PORT_W];
          ev_dir  <= head_entry[EW-1-IDX_W-PORT_W -: PORT_W];
          ev_time <= head_entry[TS_W:1];
          ev_lost <= head_entry[0];
        end
      end
    end
  end
endmodule

// File: tb/tb_gpio_event_logger.sv
// tb/tb_gpio_event_logger.sv - directed self-checking bench for gpio_event_logger
module tb_gpio_event_logger;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, clear, ev_ready;
  logic [2:0]  watch_mask;
  logic [23:0] port_out, port_dir;
  logic        ev_valid, ev_lost;
  logic [2:0]  ev_port;
  logic [7:0]  ev_data, ev_dir;
  logic [31:0] ev_time;
  logic [15:0] drop_count;
  logic [4:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  logic [31:0] ts_model;
  logic [31:0] t_k;

  gpio_event_logger dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
    .watch_mask(watch_mask), .port_out(port_out), .port_dir(port_dir),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_port(ev_port),
    .ev_data(ev_data), .ev_dir(ev_dir), .ev_time(ev_time), .ev_lost(ev_lost),
    .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ts_model <= '0;
    else if (clear) ts_model <= '0;
    else            ts_model <= ts_model + 32'd1;
  end

  typedef struct {
    logic [23:0] po;
    logic [23:0] pd;
    logic [2:0]  mask;
    logic        en;
    logic        exp_v;
    logic [2:0]  exp_port;
    logic [7:0]  exp_data;
    logic [7:0]  exp_dir;
  } vec_t;
  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_p0  [7];
  logic       rr_v   [7];
  logic [2:0] rr_prt [7];
  logic [7:0] rr_dat [7];
  logic       rr_lst [7];

  initial begin
    vecs[0] = '{24'h002000, 24'h000000, 3'b111, 1'b1, 1'b1, 3'd1, 8'h20, 8'h00};
    vecs[1] = '{24'h002000, 24'h000F00, 3'b111, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[2] = '{24'h00205A, 24'h000F00, 3'b111, 1'b1, 1'b1, 3'd0, 8'h5A, 8'h00};
    vecs[3] = '{24'h81205A, 24'hFF0F00, 3'b111, 1'b1, 1'b1, 3'd2, 8'h81, 8'hFF};
    vecs[4] = '{24'h81FF5A, 24'hFF0F00, 3'b101, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[5] = '{24'h81FF5A, 24'hFF0F00, 3'b111, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[6] = '{24'h810F5A, 24'hFF0F00, 3'b111, 1'b1, 1'b1, 3'd1, 8'h0F, 8'h0F};
    vecs[7] = '{24'h000F5A, 24'hFF0F00, 3'b111, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[8] = '{24'h000F5A, 24'hFF0F00, 3'b111, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00};
    vecs[9] = '{24'h550F5A, 24'hFF0F00, 3'b111, 1'b1, 1'b1, 3'd2, 8'h55, 8'hFF};

    rr_p0  = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01};
    rr_v   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    rr_prt = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0};
    rr_dat = '{8'h00, 8'h01, 8'h44, 8'h66, 8'h02, 8'h01, 8'h00};
    rr_lst = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; ev_ready = 1'b0;
    watch_mask = 3'b111; port_out = '0; port_dir = '0;
    tick(); tick();
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single-change vectors: detection, latency, masking, enable, direction-only
    for (int i = 0; i < 10; i++) begin
      port_out = vecs[i].po; port_dir = vecs[i].pd;
      watch_mask = vecs[i].mask; enable = vecs[i].en;
      t_k = ts_model;
      tick(); tick();
      chk($sformatf("v%0d_valid", i), 32'(ev_valid), 32'(vecs[i].exp_v));
      if (vecs[i].exp_v) begin
        chk($sformatf("v%0d_port", i), 32'(ev_port), 32'(vecs[i].exp_port));
        chk($sformatf("v%0d_data", i), 32'(ev_data), 32'(vecs[i].exp_data));
        chk($sformatf("v%0d_dir", i), 32'(ev_dir), 32'(vecs[i].exp_dir));
        chk($sformatf("v%0d_time", i), ev_time, t_k);
        chk($sformatf("v%0d_lost", i), 32'(ev_lost), 32'd0);
        chk($sformatf("v%0d_level", i), 32'(fifo_level), 32'd1);
        ev_ready = 1'b1; tick(); ev_ready = 1'b0;
      end
      chk($sformatf("v%0d_level_end", i), 32'(fifo_level), 32'd0);
    end

    // Three simultaneous changes drain in port order 0,1,2
    ev_ready = 1'b1;
    port_out = 24'h112233;
    t_k = ts_model;
    tick(); tick();
    chk("sim_p0_port", 32'(ev_port), 32'd0);
    chk("sim_p0_data", 32'(ev_data), 32'h33);
    chk("sim_p0_time", ev_time, t_k);
    tick();
    chk("sim_p1_port", 32'(ev_port), 32'd1);
    chk("sim_p1_data", 32'(ev_data), 32'h22);
    tick();
    chk("sim_p2_port", 32'(ev_port), 32'd2);
    chk("sim_p2_data", 32'(ev_data), 32'h11);
    chk("sim_p2_time", ev_time, t_k);
    tick();
    chk("sim_empty", 32'(ev_valid), 32'd0);

    // Port 0 toggling every cycle must not starve ports 1 and 2
    port_out[23:8] = 16'h6644;
    for (int i = 0; i < 7; i++) begin
      port_out[7:0] = rr_p0[i];
      tick();
      chk($sformatf("rr%0d_valid", i), 32'(ev_valid), 32'(rr_v[i]));
      if (rr_v[i]) begin
        chk($sformatf("rr%0d_port", i), 32'(ev_port), 32'(rr_prt[i]));
        chk($sformatf("rr%0d_data", i), 32'(ev_data), 32'(rr_dat[i]));
        chk($sformatf("rr%0d_lost", i), 32'(ev_lost), 32'(rr_lst[i]));
      end
    end
    chk("rr_drop", 32'(drop_count), 32'd2);
    ev_ready = 1'b0;

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr0_drop", 32'(drop_count), 32'd0);
    chk("clr0_valid", 32'(ev_valid), 32'd0);

    // Full FIFO with coalescing of the trailing toggles
    for (int i = 1; i <= 20; i++) begin
      port_out[7:0] = 8'(8'h80 + i);
      if (i == 20) t_k = ts_model;
      tick();
    end
    tick();
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_drop", 32'(drop_count), 32'd3);
    ev_ready = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      chk($sformatf("drain%0d_valid", j), 32'(ev_valid), 32'd1);
      chk($sformatf("drain%0d_data", j), 32'(ev_data), (j == 17) ? 32'h94 : 32'(8'h80 + j));
      chk($sformatf("drain%0d_lost", j), 32'(ev_lost), (j == 17) ? 32'd1 : 32'd0);
      if (j == 17) chk("drain17_time", ev_time, t_k);
      tick();
    end
    ev_ready = 1'b0;
    chk("drain_empty", 32'(ev_valid), 32'd0);
    chk("drain_level", 32'(fifo_level), 32'd0);

    // Clear with entries queued, a pending port and a simultaneous pop
    for (int i = 0; i < 5; i++) begin
      port_out[15:8] = 8'(8'h31 + i);
      tick();
    end
    port_out[23:16] = 8'h99;
    tick();
    chk("fill_level", 32'(fifo_level), 32'd5);
    clear = 1'b1; ev_ready = 1'b1;
    tick();
    clear = 1'b0; ev_ready = 1'b0;
    chk("clr_valid", 32'(ev_valid), 32'd0);
    chk("clr_level", 32'(fifo_level), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);
    port_out[15:8] = 8'h77;
    tick(); tick();
    chk("postclr_port", 32'(ev_port), 32'd1);
    chk("postclr_data", 32'(ev_data), 32'h77);
    chk("postclr_time", ev_time, 32'd0);
    chk("postclr_level", 32'(fifo_level), 32'd1);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    chk("postclr_empty", 32'(ev_valid), 32'd0);

    // Asynchronous reset with an entry queued and a port pending
    port_out[7:0] = 8'h0A;
    tick(); tick();
    port_out[23:16] = 8'h5C;
    tick();
    chk("prerst_data", 32'(ev_data), 32'h0A);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ev_valid), 32'd0);
    chk("arst_level", 32'(fifo_level), 32'd0);
    chk("arst_data", 32'(ev_data), 32'd0);
    chk("arst_time", ev_time, 32'd0);
    chk("arst_drop", 32'(drop_count), 32'd0);
    #1 rst_n = 1'b1;
    tick(); tick();
    chk("postrst_valid", 32'(ev_valid), 32'd1);
    chk("postrst_port", 32'(ev_port), 32'd0);
    chk("postrst_data", 32'(ev_data), 32'h0A);
    chk("postrst_time", ev_time, 32'd0);
    tick();
    chk("postrst_level", 32'(fifo_level), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
